mem_port_arbiter: RTL and testbench

Shares one single-port, variable-latency memory between the instruction-fetch requester and the load/store (MEM-stage) requester of the RISC-V core. Load/store has fixed priority, bounded by an anti-starvation counter for fetch. The block generates byte enables and write-data lane replication from the S-type funct3 encoding (SB/SH/SW). It also extracts and sign- or zero-extends load data from the I-type LOAD funct3 encoding (LB/LH/LW/LBU/LHU).

---
 rtl/mem_port_arbiter_if.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// =============================================================================
// Module      : mem_port_arbiter_if
// Description : Fetch, load/store and memory-side bus bundle for mem_port_arbiter.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        dm_req;
    logic        dm_we;
    logic [2:0]  dm_funct3;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        dm_misalign;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    // Arbiter side: serves the two requesters and masters the memory port.
    modport master (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_funct3, dm_addr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata, dm_misalign,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    // Environment side: requesters and the memory itself.
    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_funct3, dm_addr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata, dm_misalign,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// =============================================================================
// Module      : mem_port_arbiter
// Description : Fetch / load-store arbiter for one variable-latency memory port.
//               Optional misaligned-access trap: MEM_PORT_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    mem_port_arbiter_if.master bus
);
    localparam logic [3:0] c_starve_limit = STARVE_LIMIT[3:0];

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_starve_cnt;
    logic        r_mem_req, r_mem_we;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_addr, r_mem_wdata;
    logic [2:0]  r_dm_funct3;
    logic [1:0]  r_dm_off;
    logic        r_if_rvalid, r_dm_rvalid;
    logic [31:0] r_if_rdata, r_dm_rdata;

    logic        w_if_gnt, w_dm_gnt, w_trap, w_misalign, w_done;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_wdata, w_ld_data;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [1:0]  w_unused_if_addr;

    assign w_unused_if_addr = bus.if_addr[1:0];
    assign w_done           = r_mem_req & bus.mem_ready;

`ifdef MEM_PORT_MISALIGN_TRAP_EN
    logic r_dm_misalign;
    assign w_misalign = ((bus.dm_funct3 == 3'b001 || (!bus.dm_we && bus.dm_funct3 == 3'b101))
                         && bus.dm_addr[0])
                      || (bus.dm_funct3 == 3'b010 && bus.dm_addr[1:0] != 2'b00);
    assign bus.dm_misalign = r_dm_misalign;
`else
    assign w_misalign      = 1'b0;
    assign bus.dm_misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Grants are gated by rst_n so a request seen during reset is never lost.
    always_comb begin
        w_state_nxt = r_state;
        w_if_gnt    = 1'b0;
        w_dm_gnt    = 1'b0;
        w_trap      = 1'b0;
        case (r_state)
            IDLE: begin
                if (rst_n) begin
                    if (bus.dm_req && !(bus.if_req && r_starve_cnt == c_starve_limit)) begin
                        w_dm_gnt = 1'b1;
                        if (w_misalign) w_trap      = 1'b1;
                        else            w_state_nxt = BUSY_DM;
                    end else if (bus.if_req) begin
                        w_if_gnt    = 1'b1;
                        w_state_nxt = BUSY_IF;
                    end
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (w_done) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_st_be    = 4'b1111;
        w_st_wdata = bus.dm_wdata;
        case (bus.dm_funct3)
            3'b000: begin
                w_st_be    = 4'b0001 << bus.dm_addr[1:0];
                w_st_wdata = {4{bus.dm_wdata[7:0]}};
            end
            3'b001: begin
                w_st_be    = bus.dm_addr[1] ? 4'b1100 : 4'b0011;
                w_st_wdata = {2{bus.dm_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_ld_byte = bus.mem_rdata[7:0];
        case (r_dm_off)
            2'd1:    w_ld_byte = bus.mem_rdata[15:8];
            2'd2:    w_ld_byte = bus.mem_rdata[23:16];
            2'd3:    w_ld_byte = bus.mem_rdata[31:24];
            default: ;
        endcase
        w_ld_half = r_dm_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (r_dm_funct3)
            3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b100:  w_ld_data = {24'd0, w_ld_byte};
            3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            3'b101:  w_ld_data = {16'd0, w_ld_half};
            default: w_ld_data = bus.mem_rdata;
        endcase
    end

    // Fetch starvation is counted only across real data grants; traps do not count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve_cnt <= 4'd0;
        end else if (w_if_gnt) begin
            r_starve_cnt <= 4'd0;
        end else if (w_dm_gnt && !w_trap && bus.if_req) begin
            if (r_starve_cnt < c_starve_limit) r_starve_cnt <= r_starve_cnt + 4'd1;
        end else if (r_state == IDLE && !bus.if_req) begin
            r_starve_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_dm_funct3 <= 3'd0;
            r_dm_off    <= 2'd0;
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            r_if_rdata  <= 32'd0;
            r_dm_rdata  <= 32'd0;
`ifdef MEM_PORT_MISALIGN_TRAP_EN
            r_dm_misalign <= 1'b0;
`endif
        end else begin
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            if (w_if_gnt) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_be    <= 4'b1111;
                r_mem_addr  <= {bus.if_addr[31:2], 2'b00};
                r_mem_wdata <= 32'd0;
            end else if (w_dm_gnt && !w_trap) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= bus.dm_we;
                r_mem_be    <= bus.dm_we ? w_st_be : 4'b1111;
                r_mem_addr  <= {bus.dm_addr[31:2], 2'b00};
                r_mem_wdata <= bus.dm_we ? w_st_wdata : 32'd0;
                r_dm_funct3 <= bus.dm_funct3;
                r_dm_off    <= bus.dm_addr[1:0];
            end else if (w_trap) begin
                r_dm_rvalid <= 1'b1;
                r_dm_rdata  <= 32'd0;
`ifdef MEM_PORT_MISALIGN_TRAP_EN
                r_dm_misalign <= 1'b1;
`endif
            end else if (w_done) begin
                r_mem_req <= 1'b0;
                if (r_state == BUSY_IF) begin
                    r_if_rvalid <= 1'b1;
                    r_if_rdata  <= bus.mem_rdata;
                end else begin
                    r_dm_rvalid <= 1'b1;
                    r_dm_rdata  <= r_mem_we ? 32'd0 : w_ld_data;
`ifdef MEM_PORT_MISALIGN_TRAP_EN
                    r_dm_misalign <= 1'b0;
`endif
                end
            end
        end
    end

    assign bus.if_gnt    = w_if_gnt;
    assign bus.dm_gnt    = w_dm_gnt;
    assign bus.if_rvalid = r_if_rvalid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_rvalid = r_dm_rvalid;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// =============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_mem_port_arbiter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    // Inputs change and outputs are sampled mid-cycle, away from the rising edge.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0; bus.dm_we = 0;
        bus.dm_funct3 = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
        bus.mem_ready = 0; bus.mem_rdata = 0;
        repeat (3) next_cycle();
        #1;
        n_checks++; if ({bus.if_gnt, bus.if_rvalid, bus.dm_gnt, bus.dm_rvalid, bus.dm_misalign} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b required 00000",
                {bus.if_gnt, bus.if_rvalid, bus.dm_gnt, bus.dm_rvalid, bus.dm_misalign}); end
        n_checks++; if ({bus.mem_req, bus.mem_we, bus.mem_be} !== 6'b0) begin
            n_fail++; $display("FAIL reset_mem_ctl: got %b required 000000", {bus.mem_req, bus.mem_we, bus.mem_be}); end
        n_checks++; if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata} !== 128'd0) begin
            n_fail++; $display("FAIL reset_data: got %h required 0", {bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata}); end
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        next_cycle();
        bus.if_req = 1; bus.if_addr = 32'h0000_0104; #1;
        n_checks++; if (bus.if_gnt !== 1'b1 || bus.dm_gnt !== 1'b0) begin
            n_fail++; $display("FAIL fetch_gnt: got if=%b dm=%b required if=1 dm=0", bus.if_gnt, bus.dm_gnt); end
        next_cycle();
        bus.if_req = 0; bus.mem_ready = 1; bus.mem_rdata = 32'h00A0_0093; #1;
        n_checks++; if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr} !== {1'b1, 1'b0, 4'b1111, 32'h104}) begin
            n_fail++; $display("FAIL fetch_mem: got req=%b we=%b be=%b addr=%h required 1 0 1111 00000104",
                bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr); end
        next_cycle();
        bus.mem_ready = 0; bus.mem_rdata = 32'hDEAD_BEEF; #1;
        n_checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h00A0_0093 || bus.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL fetch_rvalid: got rvalid=%b rdata=%h mem_req=%b required 1 00a00093 0",
                bus.if_rvalid, bus.if_rdata, bus.mem_req); end
        next_cycle(); #1;
        n_checks++; if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'h00A0_0093) begin
            n_fail++; $display("FAIL fetch_hold: got rvalid=%b rdata=%h required 0 00a00093", bus.if_rvalid, bus.if_rdata); end
    endtask

    task automatic test_store();
        logic [2:0]  f3    [3] = '{3'b000, 3'b001, 3'b010};
        logic [31:0] addr  [3] = '{32'h203, 32'h206, 32'h208};
        logic [31:0] wd    [3] = '{32'h1234_5678, 32'hAAAA_BEEF, 32'hCAFE_F00D};
        logic [3:0]  e_be  [3] = '{4'b1000, 4'b1100, 4'b1111};
        logic [31:0] e_wd  [3] = '{32'h7878_7878, 32'hBEEF_BEEF, 32'hCAFE_F00D};
        logic [31:0] e_ad  [3] = '{32'h200, 32'h204, 32'h208};
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            bus.dm_req = 1; bus.dm_we = 1; bus.dm_funct3 = f3[i]; bus.dm_addr = addr[i]; bus.dm_wdata = wd[i]; #1;
            n_checks++; if (bus.dm_gnt !== 1'b1) begin
                n_fail++; $display("FAIL store_gnt[%0d]: got %b required 1", i, bus.dm_gnt); end
            next_cycle();
            bus.dm_req = 0; bus.mem_ready = 1; #1;
            n_checks++; if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, e_be[i], e_ad[i], e_wd[i]}) begin
                n_fail++; $display("FAIL store_mem[%0d]: got req=%b we=%b be=%b addr=%h wdata=%h required 1 1 %b %h %h",
                    i, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata, e_be[i], e_ad[i], e_wd[i]); end
            next_cycle();
            bus.mem_ready = 0; #1;
            n_checks++; if (bus.dm_rvalid !== 1'b1 || bus.dm_rdata !== 32'd0 || bus.dm_misalign !== 1'b0) begin
                n_fail++; $display("FAIL store_rvalid[%0d]: got rvalid=%b rdata=%h mis=%b required 1 0 0",
                    i, bus.dm_rvalid, bus.dm_rdata, bus.dm_misalign); end
        end
    endtask

    // Loads issued back to back: each new request is granted in the previous one's rvalid cycle.
    task automatic test_back_to_back_loads();
        logic [2:0]  f3   [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] addr [5] = '{32'h2, 32'h3, 32'h2, 32'h0, 32'h4};
        logic [31:0] exp  [5] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            bus.mem_ready = 0;
            bus.dm_req = 1; bus.dm_we = 0; bus.dm_funct3 = f3[i]; bus.dm_addr = addr[i]; #1;
            n_checks++; if (bus.dm_gnt !== 1'b1) begin
                n_fail++; $display("FAIL load_gnt[%0d]: got %b required 1", i, bus.dm_gnt); end
            if (i > 0) begin
                n_checks++; if (bus.dm_rvalid !== 1'b1 || bus.dm_rdata !== exp[i-1]) begin
                    n_fail++; $display("FAIL load_data[%0d]: got rvalid=%b rdata=%h required 1 %h",
                        i-1, bus.dm_rvalid, bus.dm_rdata, exp[i-1]); end
            end
            next_cycle();
            bus.dm_req = 0; bus.mem_ready = 1; bus.mem_rdata = 32'h80FF_7F01; #1;
            n_checks++; if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr} !== {1'b1, 1'b0, 4'b1111, addr[i] & 32'hFFFF_FFFC}) begin
                n_fail++; $display("FAIL load_mem[%0d]: got req=%b we=%b be=%b addr=%h required 1 0 1111 %h",
                    i, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, addr[i] & 32'hFFFF_FFFC); end
        end
        next_cycle();
        bus.mem_ready = 0; #1;
        n_checks++; if (bus.dm_rvalid !== 1'b1 || bus.dm_rdata !== exp[4]) begin
            n_fail++; $display("FAIL load_data[4]: got rvalid=%b rdata=%h required 1 %h", bus.dm_rvalid, bus.dm_rdata, exp[4]); end
    endtask

    task automatic test_starvation();
        logic [9:0] exp_order = 10'b10_0001_0000;
        int         n_gnt = 0;
        next_cycle();
        bus.if_req = 1; bus.if_addr = 32'h300; bus.dm_req = 1; bus.dm_we = 0;
        bus.dm_funct3 = 3'b010; bus.dm_addr = 32'h400; bus.mem_ready = 1;
        for (int c = 0; c < 40 && n_gnt < 10; c++) begin
            if (c > 0) next_cycle();
            #1;
            if (bus.if_gnt === 1'b1 || bus.dm_gnt === 1'b1) begin
                n_checks++; if ({bus.if_gnt, bus.dm_gnt} !== {exp_order[n_gnt], ~exp_order[n_gnt]}) begin
                    n_fail++; $display("FAIL starve_order[%0d]: got if=%b dm=%b required if=%b dm=%b",
                        n_gnt, bus.if_gnt, bus.dm_gnt, exp_order[n_gnt], ~exp_order[n_gnt]); end
                n_gnt++;
            end
        end
        n_checks++; if (n_gnt != 10) begin
            n_fail++; $display("FAIL starve_count: got %0d grants required 10", n_gnt); end
        next_cycle();
        bus.if_req = 0; bus.dm_req = 0;
        next_cycle();
        bus.mem_ready = 0;
    endtask

    task automatic test_wait_reset();
        next_cycle();
        bus.if_req = 1; bus.if_addr = 32'h40; #1;
        n_checks++; if (bus.if_gnt !== 1'b1) begin
            n_fail++; $display("FAIL wait_gnt: got %b required 1", bus.if_gnt); end
        next_cycle();
        bus.if_req = 0; bus.dm_req = 1; bus.dm_we = 0; bus.dm_funct3 = 3'b010; bus.dm_addr = 32'h10;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) next_cycle();
            #1;
            n_checks++; if ({bus.mem_req, bus.mem_addr, bus.dm_gnt, bus.if_rvalid} !== {1'b1, 32'h40, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL wait_busy[%0d]: got req=%b addr=%h dm_gnt=%b rvalid=%b required 1 00000040 0 0",
                    c, bus.mem_req, bus.mem_addr, bus.dm_gnt, bus.if_rvalid); end
        end
        next_cycle();
        bus.dm_req = 0; rst_n = 0; bus.mem_ready = 1; bus.mem_rdata = 32'h5555_AAAA;
        next_cycle();
        rst_n = 1; bus.mem_ready = 0; bus.if_req = 1; bus.if_addr = 32'h80; #1;
        n_checks++; if ({bus.mem_req, bus.if_rvalid, bus.dm_rvalid, bus.if_gnt} !== 4'b0001) begin
            n_fail++; $display("FAIL reset_abort: got req=%b if_rv=%b dm_rv=%b if_gnt=%b required 0 0 0 1",
                bus.mem_req, bus.if_rvalid, bus.dm_rvalid, bus.if_gnt); end
        next_cycle();
        bus.if_req = 0; bus.mem_ready = 1; bus.mem_rdata = 32'h0000_0013; #1;
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h80) begin
            n_fail++; $display("FAIL reset_refetch_mem: got req=%b addr=%h required 1 00000080", bus.mem_req, bus.mem_addr); end
        next_cycle();
        bus.mem_ready = 0; #1;
        n_checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h0000_0013) begin
            n_fail++; $display("FAIL reset_refetch_data: got rvalid=%b rdata=%h required 1 00000013", bus.if_rvalid, bus.if_rdata); end
    endtask

    task automatic test_misalign();
        next_cycle();
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_funct3 = 3'b010; bus.dm_addr = 32'h102; #1;
        n_checks++; if (bus.dm_gnt !== 1'b1) begin
            n_fail++; $display("FAIL misalign_gnt: got %b required 1", bus.dm_gnt); end
        next_cycle();
        bus.dm_req = 0; bus.mem_ready = 1; bus.mem_rdata = 32'h1122_3344; #1;
`ifdef MEM_PORT_MISALIGN_TRAP_EN
        n_checks++; if ({bus.mem_req, bus.dm_rvalid, bus.dm_misalign, bus.dm_rdata} !== {3'b011, 32'd0}) begin
            n_fail++; $display("FAIL misalign_trap: got req=%b rvalid=%b mis=%b rdata=%h required 0 1 1 00000000",
                bus.mem_req, bus.dm_rvalid, bus.dm_misalign, bus.dm_rdata); end
        next_cycle();
        bus.mem_ready = 0;
`else
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin
            n_fail++; $display("FAIL misalign_mem: got req=%b addr=%h required 1 00000100", bus.mem_req, bus.mem_addr); end
        next_cycle();
        bus.mem_ready = 0; #1;
        n_checks++; if ({bus.dm_rvalid, bus.dm_misalign, bus.dm_rdata} !== {2'b10, 32'h1122_3344}) begin
            n_fail++; $display("FAIL misalign_data: got rvalid=%b mis=%b rdata=%h required 1 0 11223344",
                bus.dm_rvalid, bus.dm_misalign, bus.dm_rdata); end
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_fetch();
        test_store();
        test_back_to_back_loads();
        test_starvation();
        test_wait_reset();
        test_misalign();
        repeat (2) next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
